// File: rtl/bht_predictor.sv
// ---------------------------------------------------------------------------
// bht_predictor -- branch history table of saturating counters.
//
// Lookup (combinational):
//   lk_pc, lk_opcode -> predicted (1 = taken), pred_idx (index carried down
//   the pipe and returned later on upd_idx).
// Update (registered, rising clk):
//   upd_valid, upd_idx, upd_taken, upd_predicted -> table counter step,
//   upd_cnt / mispred_cnt statistics (16-bit, saturating).
// reset: synchronous, active-high; it wins over a coincident update.
//
// Optional feature: define BHT_GSHARE_EN to XOR a global history register
// (GHR_BITS wide, fed by resolved outcomes) into the lookup index. The
// update path always uses upd_idx, so the hash is never recomputed there.
// ---------------------------------------------------------------------------
module bht_predictor #(
  parameter int         IDX_BITS = 6,
  parameter int         CTR_BITS = 2,
  parameter int         GHR_BITS = 6,
  parameter logic [6:0] BOP      = 7'h63,
  parameter logic [6:0] JALOP    = 7'h6F,
  parameter logic [6:0] JALROP   = 7'h67
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         lk_pc,
  input  logic [6:0]          lk_opcode,
  output logic                predicted,
  output logic [IDX_BITS-1:0] pred_idx,
  input  logic                upd_valid,
  input  logic [IDX_BITS-1:0] upd_idx,
  input  logic                upd_taken,
  input  logic                upd_predicted,
  output logic [15:0]         mispred_cnt,
  output logic [15:0]         upd_cnt
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0] CTR_MIN  = '0;
  // Weakly not-taken: MSB clear, all lower bits set.
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

  logic [CTR_BITS-1:0] table_reg  [ENTRIES];
  logic [CTR_BITS-1:0] table_next [ENTRIES];
  logic [15:0]         upd_cnt_reg, upd_cnt_next;
  logic [15:0]         mispred_cnt_reg, mispred_cnt_next;
  logic [IDX_BITS-1:0] pc_idx;

  // PC bits outside the index field (and the word-offset bits) are unused.
  logic unused_pc_bits;
  assign unused_pc_bits = &{1'b0, lk_pc[31:IDX_BITS+2], lk_pc[1:0]};

  assign pc_idx = lk_pc[IDX_BITS+1:2];

`ifdef BHT_GSHARE_EN
  logic [GHR_BITS-1:0] ghr_reg, ghr_next;

  // Newest outcome enters at bit 0; oldest falls off the top.
  assign ghr_next = upd_valid ? ((ghr_reg << 1) | GHR_BITS'(upd_taken)) : ghr_reg;
  assign pred_idx = pc_idx ^ IDX_BITS'(ghr_reg);

  always_ff @(posedge clk) begin
    if (reset) ghr_reg <= '0;
    else       ghr_reg <= ghr_next;
  end
`else
  localparam int unused_ghr_bits = GHR_BITS;
  assign pred_idx = pc_idx;
`endif

  // Per-entry next state: only the addressed entry moves, saturating at both ends.
  generate
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
      logic hit;
      assign hit = upd_valid && (upd_idx == IDX_BITS'(gi));
      assign table_next[gi] =
          !hit                                 ? table_reg[gi] :
          (upd_taken  && table_reg[gi] != CTR_MAX) ? table_reg[gi] + 1'b1 :
          (!upd_taken && table_reg[gi] != CTR_MIN) ? table_reg[gi] - 1'b1 :
                                                 table_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < ENTRIES; i++) begin
      if (reset) table_reg[i] <= CTR_INIT;
      else       table_reg[i] <= table_next[i];
    end
  end

  always_comb begin
    upd_cnt_next     = upd_cnt_reg;
    mispred_cnt_next = mispred_cnt_reg;
    if (upd_valid) begin
      if (upd_cnt_reg != 16'hFFFF) upd_cnt_next = upd_cnt_reg + 16'd1;
      if ((upd_taken != upd_predicted) && (mispred_cnt_reg != 16'hFFFF))
        mispred_cnt_next = mispred_cnt_reg + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      upd_cnt_reg     <= '0;
      mispred_cnt_reg <= '0;
    end else begin
      upd_cnt_reg     <= upd_cnt_next;
      mispred_cnt_reg <= mispred_cnt_next;
    end
  end

  assign upd_cnt     = upd_cnt_reg;
  assign mispred_cnt = mispred_cnt_reg;

  // Read returns the pre-update value; a same-cycle write shows up next cycle.
  always_comb begin
    predicted = 1'b0;
    if (lk_opcode == BOP)
      predicted = table_reg[pred_idx][CTR_BITS-1];
    else if (lk_opcode == JALOP || lk_opcode == JALROP)
      predicted = 1'b1;
  end

endmodule

// File: tb/tb_bht_predictor.sv
module tb_bht_predictor;

  localparam logic [6:0] BOP    = 7'h63;
  localparam logic [6:0] JALOP  = 7'h6F;
  localparam logic [6:0] JALROP = 7'h67;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] lk_pc;
  logic [6:0]  lk_opcode;
  logic        predicted;
  logic [5:0]  pred_idx;
  logic        upd_valid;
  logic [5:0]  upd_idx;
  logic        upd_taken;
  logic        upd_predicted;
  logic [15:0] mispred_cnt;
  logic [15:0] upd_cnt;

  int errors = 0;
  int checks = 0;

  bht_predictor dut (
    .clk(clk), .reset(reset), .lk_pc(lk_pc), .lk_opcode(lk_opcode),
    .predicted(predicted), .pred_idx(pred_idx), .upd_valid(upd_valid),
    .upd_idx(upd_idx), .upd_taken(upd_taken), .upd_predicted(upd_predicted),
    .mispred_cnt(mispred_cnt), .upd_cnt(upd_cnt)
  );

  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; upd_valid = 1'b0;
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic do_update(input logic [5:0] idx, input logic taken, input logic pred);
    upd_valid = 1'b1; upd_idx = idx; upd_taken = taken; upd_predicted = pred;
    tick();
    upd_valid = 1'b0;
    #1;
    $display("upd idx=0x%02h taken=%0b pred=%0b -> upd_cnt=%0d mispred_cnt=%0d",
             idx, taken, pred, upd_cnt, mispred_cnt);
  endtask

  task automatic lookup(input logic [31:0] pc, input logic [6:0] op);
    lk_pc = pc; lk_opcode = op;
    #1;
    $display("lookup pc=0x%08h op=0x%02h -> predicted=%0b pred_idx=0x%02h",
             pc, op, predicted, pred_idx);
  endtask

  task automatic test_reset();
    do_reset();
    lookup(32'h40, BOP);
    checks++; if (predicted !== 1'b0) begin errors++; $display("FAIL reset_pred got=%0b exp=0", predicted); end
    checks++; if (pred_idx !== 6'h10) begin errors++; $display("FAIL reset_idx got=0x%02h exp=0x10", pred_idx); end
    checks++; if (upd_cnt !== 16'd0) begin errors++; $display("FAIL reset_upd_cnt got=%0d exp=0", upd_cnt); end
    checks++; if (mispred_cnt !== 16'd0) begin errors++; $display("FAIL reset_mispred_cnt got=%0d exp=0", mispred_cnt); end
    lookup(32'hFFFF_FFFF, BOP);
    checks++; if (pred_idx !== 6'h3F) begin errors++; $display("FAIL idx_top got=0x%02h exp=0x3f", pred_idx); end
`ifndef BHT_GSHARE_EN
    lookup(32'h0000_0043, BOP);
    checks++; if (pred_idx !== 6'h10) begin errors++; $display("FAIL idx_offset got=0x%02h exp=0x10", pred_idx); end
`endif
  endtask

  task automatic test_saturate();
    do_reset();
    lookup(32'h40, BOP);
    do_update(6'h10, 1'b1, 1'b0);   // 01 -> 10
    do_update(6'h10, 1'b1, 1'b1);   // 10 -> 11
    checks++; if (predicted !== 1'b1) begin errors++; $display("FAIL sat_taken got=%0b exp=1", predicted); end
    do_update(6'h10, 1'b1, 1'b1);   // holds at 11
    checks++; if (predicted !== 1'b1) begin errors++; $display("FAIL sat_hold_hi got=%0b exp=1", predicted); end
    do_update(6'h10, 1'b0, 1'b1);   // 11 -> 10
    checks++; if (predicted !== 1'b1) begin errors++; $display("FAIL sat_dec1 got=%0b exp=1", predicted); end
    do_update(6'h10, 1'b0, 1'b1);   // 10 -> 01
    checks++; if (predicted !== 1'b0) begin errors++; $display("FAIL sat_dec2 got=%0b exp=0", predicted); end
    do_update(6'h10, 1'b0, 1'b0);   // 01 -> 00
    do_update(6'h10, 1'b0, 1'b0);   // holds at 00
    do_update(6'h10, 1'b1, 1'b0);   // 00 -> 01
    checks++; if (predicted !== 1'b0) begin errors++; $display("FAIL sat_hold_lo got=%0b exp=0", predicted); end
    do_update(6'h10, 1'b1, 1'b0);   // 01 -> 10
    checks++; if (predicted !== 1'b1) begin errors++; $display("FAIL sat_lo_inc got=%0b exp=1", predicted); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    lookup(32'h40, BOP);
    upd_valid = 1'b1; upd_idx = 6'h10; upd_taken = 1'b1; upd_predicted = 1'b0;
    #1;
    checks++; if (predicted !== 1'b0) begin errors++; $display("FAIL same_cycle_pre got=%0b exp=0", predicted); end
    tick();
    upd_valid = 1'b0;
    #1;
    checks++; if (predicted !== 1'b1) begin errors++; $display("FAIL same_cycle_post got=%0b exp=1", predicted); end
  endtask

  task automatic test_jal();
    do_reset();
    lookup(32'h40, JALOP);
    checks++; if (predicted !== 1'b1) begin errors++; $display("FAIL jal got=%0b exp=1", predicted); end
    lookup(32'h40, JALROP);
    checks++; if (predicted !== 1'b1) begin errors++; $display("FAIL jalr got=%0b exp=1", predicted); end
    lookup(32'h40, 7'h33);
    checks++; if (predicted !== 1'b0) begin errors++; $display("FAIL other_op got=%0b exp=0", predicted); end
    // Idle update fields with upd_valid low must not move the table.
    upd_valid = 1'b0; upd_idx = 6'h10; upd_taken = 1'b1; upd_predicted = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    lookup(32'h40, BOP);
    checks++; if (predicted !== 1'b0) begin errors++; $display("FAIL idle_no_change got=%0b exp=0", predicted); end
    checks++; if (upd_cnt !== 16'd0) begin errors++; $display("FAIL idle_upd_cnt got=%0d exp=0", upd_cnt); end
  endtask

  task automatic test_counts();
    do_reset();
    lookup(32'h40, BOP);
    do_update(6'h10, 1'b1, 1'b0);   // mispredict
    do_update(6'h10, 1'b1, 1'b1);
    do_update(6'h05, 1'b0, 1'b0);
    do_update(6'h3F, 1'b0, 1'b1);   // mispredict
    do_update(6'h00, 1'b1, 1'b1);
    checks++; if (upd_cnt !== 16'd5) begin errors++; $display("FAIL upd_cnt got=%0d exp=5", upd_cnt); end
    checks++; if (mispred_cnt !== 16'd2) begin errors++; $display("FAIL mispred_cnt got=%0d exp=2", mispred_cnt); end
    checks++; if (predicted !== 1'b1) begin errors++; $display("FAIL pre_reset_pred got=%0b exp=1", predicted); end
    // Reset coincident with an update: update discarded.
    reset = 1'b1; upd_valid = 1'b1; upd_idx = 6'h10; upd_taken = 1'b1; upd_predicted = 1'b0;
    tick();
    reset = 1'b0; upd_valid = 1'b0;
    #1;
    checks++; if (upd_cnt !== 16'd0) begin errors++; $display("FAIL rst_upd_cnt got=%0d exp=0", upd_cnt); end
    checks++; if (mispred_cnt !== 16'd0) begin errors++; $display("FAIL rst_mispred_cnt got=%0d exp=0", mispred_cnt); end
    checks++; if (predicted !== 1'b0) begin errors++; $display("FAIL rst_table got=%0b exp=0", predicted); end
    do_update(6'h10, 1'b1, 1'b0);   // 01 -> 10 proves the entry was 01
    checks++; if (predicted !== 1'b1) begin errors++; $display("FAIL rst_table_01 got=%0b exp=1", predicted); end
  endtask

`ifdef BHT_GSHARE_EN
  task automatic test_gshare();
    do_reset();
    do_update(6'h01, 1'b1, 1'b0);
    do_update(6'h01, 1'b1, 1'b0);
    do_update(6'h01, 1'b0, 1'b0);
    lookup(32'h40, BOP);
    checks++; if (pred_idx !== 6'h16) begin errors++; $display("FAIL gshare_idx got=0x%02h exp=0x16", pred_idx); end
  endtask
`endif

  initial begin
    reset = 1'b1; lk_pc = '0; lk_opcode = '0;
    upd_valid = 1'b0; upd_idx = '0; upd_taken = 1'b0; upd_predicted = 1'b0;
    test_reset();
    test_saturate();
    test_same_cycle();
    test_jal();
    test_counts();
`ifdef BHT_GSHARE_EN
    test_gshare();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bht_predictor.md
BHT_PREDICTOR -- requirements
Module: bht_predictor

Interface
REQ-001 SHALL provide parameter IDX_BITS, default 6, table index width (2^IDX_BITS entries).
REQ-002 SHALL provide parameter CTR_BITS, default 2, saturating counter width per entry (legal 2..4).
REQ-003 SHALL provide parameter GHR_BITS, default 6, global history width (used only under GSHARE_EN; legal 1..IDX_BITS).
REQ-004 SHALL provide parameters BOP 7'h63, JALOP 7'h6F, JALROP 7'h67, opcode encodings.
REQ-005 SHALL have port clk, input, 1, rising-edge clock.
REQ-006 SHALL have port reset, input, 1, reset (synchronous, active-high).
REQ-007 SHALL have port lk_pc, input, 32, PC of the instruction being predicted.
REQ-008 SHALL have port lk_opcode, input, 7, opcode of the instruction being predicted.
REQ-009 SHALL have port predicted, output, 1, 1 = taken, 0 = not taken.
REQ-010 SHALL have port pred_idx, output, IDX_BITS, table index used for this lookup; carried down the pipe.
REQ-011 SHALL have port upd_valid, input, 1, resolved conditional branch this cycle.
REQ-012 SHALL have port upd_idx, input, IDX_BITS, pred_idx captured at lookup.
REQ-013 SHALL have port upd_taken, input, 1, actual outcome.
REQ-014 SHALL have port upd_predicted, input, 1, prediction made at lookup.
REQ-015 SHALL have port mispred_cnt, output, 16, count of mispredicted updates.
REQ-016 SHALL have port upd_cnt, output, 16, count of updates.

Function
REQ-017 SHALL hold a table of 2^IDX_BITS counters, CTR_BITS wide each, in flops.
REQ-018 SHALL compute pred_idx = lk_pc[IDX_BITS+1:2] (macro absent); combinational, same cycle.
REQ-019 SHALL drive predicted combinationally: BOP -> MSB of table[pred_idx]; JALOP/JALROP -> 1; any other opcode -> 0.
REQ-020 SHALL, on a clock edge with upd_valid=1, increment table[upd_idx] if upd_taken=1, else decrement; saturate at 2^CTR_BITS-1 and 0.
REQ-021 SHALL leave the table unchanged when upd_valid=0.
REQ-022 SHALL, when lookup and update hit the same index in one cycle, return the pre-update value (no bypass); the new value is visible the next cycle.
REQ-023 SHALL increment upd_cnt by 1 per upd_valid edge; saturate at 16'hFFFF.
REQ-024 SHALL increment mispred_cnt by 1 per upd_valid edge with upd_taken != upd_predicted; saturate at 16'hFFFF.
REQ-025 SHALL ignore upd_* fields when upd_valid=0; non-branch opcodes never update the table.

Reset
REQ-026 SHALL, on a clock edge with reset=1, set every counter to 2^(CTR_BITS-1)-1 (weakly not-taken; 2'b01 at default), the GHR to 0, and upd_cnt and mispred_cnt to 0.
REQ-027 SHALL give reset priority over a simultaneous upd_valid; that update is discarded.
REQ-028 SHALL drive predicted=0 for BOP lookups in the cycle after reset (weakly not-taken MSB=0).

Configuration
REQ-029 SHALL, with macro BHT_GSHARE_EN defined, keep a GHR_BITS global history register, shifted left with upd_taken into bit 0 on each upd_valid edge, and compute pred_idx = lk_pc[IDX_BITS+1:2] XOR zero-extended GHR.
REQ-030 SHALL, without BHT_GSHARE_EN, contain no GHR flops and index by PC bits alone.
REQ-031 SHALL keep the update path the same in both modes: it indexes by upd_idx and never recomputes the hash.

Verification
REQ-032 SHALL cover: reset, then BOP lookup at lk_pc=0x40 -> predicted=0, pred_idx=0x10.
REQ-033 SHALL cover: two updates at idx 0x10 with taken=1 -> counter 01->10->11; BOP lookup at 0x40 -> predicted=1; a third taken update holds at 11.
REQ-034 SHALL cover: lookup and update at idx 0x10 in one cycle (counter 01, taken=1) -> predicted=0 that cycle, predicted=1 the next cycle.
REQ-035 SHALL cover: JALOP and JALROP at a not-taken index -> predicted=1; opcode 7'h33 -> predicted=0 with no table change.
REQ-036 SHALL cover: 5 updates, 2 with upd_taken!=upd_predicted -> upd_cnt=5, mispred_cnt=2; reset asserted with upd_valid=1 -> counts 0, table back to 01.
REQ-037 SHALL cover, with BHT_GSHARE_EN: updates taken, taken, not-taken -> GHR=6'b000110; lookup lk_pc=0x40 -> pred_idx=0x16.
